// File: rtl/button_pkg.sv
// Shared types and limits for the button event arbiter.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      HOLD  = 2'd2
   } arb_state_t;

   localparam int unsigned MAX_BTN = 8;
   localparam int unsigned HOLD_W  = 4;

endpackage : button_pkg

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first set request strictly after i_last, wrapping around.
module rr_priority_picker #(
   parameter int unsigned N_BTN = 5,
   parameter int unsigned IDW   = $clog2(N_BTN)
) (
   input  logic [N_BTN-1:0] i_req,
   input  logic [IDW-1:0]   i_last,
   output logic             o_any,
   output logic [IDW-1:0]   o_pick
);

   localparam int unsigned SW = IDW + 1;

   logic [IDW-1:0]   w_start;
   logic [N_BTN-1:0] w_rot;
   logic [IDW-1:0]   w_off;
   logic [SW-1:0]    w_sum;

   // Rotate requests so the slot after i_last sits at bit 0, then find lowest set bit.
   always_comb begin
      w_start = (i_last >= IDW'(N_BTN - 1)) ? '0 : IDW'(i_last + IDW'(1));
      w_rot   = N_BTN'({i_req, i_req} >> w_start);
      w_off   = '0;
      for (int k = N_BTN - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = IDW'(k);
      end
      w_sum  = SW'(w_start) + SW'(w_off);
      o_any  = |i_req;
      o_pick = (w_sum >= SW'(N_BTN)) ? IDW'(w_sum - SW'(N_BTN)) : IDW'(w_sum);
   end

endmodule : rr_priority_picker

// File: rtl/button_event_arbiter.sv
// Latches one-shot button pulses and offers them round-robin on a
// valid/ready channel, with an idle hold-off gap after every accepted event.
module button_event_arbiter
   import button_pkg::*;
#(
   parameter int unsigned N_BTN   = 5,
   parameter int unsigned IDW     = $clog2(N_BTN),
   parameter int unsigned HOLDOFF = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] i_pulse,
   output logic             o_valid,
   output logic [IDW-1:0]   o_id,
   input  logic             i_ready,
   output logic             o_overrun,
   output logic             o_busy
);

   arb_state_t        r_state, w_state_nxt;
   logic [N_BTN-1:0]  r_pending, w_pending_nxt;
   logic              r_valid, w_valid_nxt;
   logic [IDW-1:0]    r_id, w_id_nxt;
   logic [IDW-1:0]    r_last, w_last_nxt;
   logic [HOLD_W-1:0] r_count, w_count_nxt;
   logic              r_overrun, w_overrun_nxt;
   logic              r_busy, w_busy_nxt;

   logic              w_accept;
   logic [N_BTN-1:0]  w_acc_mask;
   logic              w_any;
   logic [IDW-1:0]    w_pick;

   rr_priority_picker #(
      .N_BTN (N_BTN),
      .IDW   (IDW)
   ) u_picker (
      .i_req  (r_pending),
      .i_last (r_last),
      .o_any  (w_any),
      .o_pick (w_pick)
   );

   // Pending bits: a new pulse wins over the clear of the accepted button.
   always_comb begin
      w_accept      = (r_state == OFFER) && r_valid && i_ready;
      w_acc_mask    = w_accept ? (N_BTN'(1) << r_id) : '0;
      w_pending_nxt = i_pulse | (r_pending & ~w_acc_mask);
      w_overrun_nxt = |(i_pulse & r_pending & ~w_acc_mask);
   end

   // Next-state and output logic for the offer/hold-off sequence.
   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = r_valid;
      w_id_nxt    = r_id;
      w_last_nxt  = r_last;
      w_count_nxt = r_count;
      case (r_state)
         IDLE: begin
            w_valid_nxt = 1'b0;
            if (w_any) begin
               w_id_nxt    = w_pick;
               w_valid_nxt = 1'b1;
               w_state_nxt = OFFER;
            end
         end
         OFFER: begin
            if (w_accept) begin
               w_valid_nxt = 1'b0;
               w_last_nxt  = r_id;
               if (HOLDOFF == 0) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_count_nxt = HOLD_W'(HOLDOFF - 1);
                  w_state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            w_valid_nxt = 1'b0;
            if (r_count == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_count_nxt = r_count - HOLD_W'(1);
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
      w_busy_nxt = (|w_pending_nxt) || (w_state_nxt != IDLE);
   end

   // State and output registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_valid   <= 1'b0;
         r_id      <= '0;
         r_last    <= IDW'(N_BTN - 1);
         r_count   <= '0;
         r_overrun <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_valid   <= w_valid_nxt;
         r_id      <= w_id_nxt;
         r_last    <= w_last_nxt;
         r_count   <= w_count_nxt;
         r_overrun <= w_overrun_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   assign o_valid   = r_valid;
   assign o_id      = r_id;
   assign o_overrun = r_overrun;
   assign o_busy    = r_busy;

endmodule : button_event_arbiter
